// File: rtl/mem_chk_pkg.sv
// Shared types for the data-memory write checker: FSM states, verdict codes
// and the table index-width helper.
package mem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ADDR    = 2'd1,
        FC_DATA    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_e;

    // Index width for an n-entry table, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exp_store_table.sv
// Expected-store register file with a matched bitmap; offers an indexed lookup
// and a lowest-index search over unmatched entries below the active count.
module exp_store_table #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_EXP  = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clr_i,
    input  logic              mark_i,
    input  logic [IDX_W-1:0]  mark_idx_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o_c,
    output logic [DATA_W-1:0] rd_data_o_c,
    input  logic [ADDR_W-1:0] srch_addr_i,
    input  logic [DATA_W-1:0] srch_data_i,
    input  logic [IDX_W:0]    srch_count_i,
    output logic              srch_hit_o_c,
    output logic              srch_data_ok_o_c,
    output logic [IDX_W-1:0]  srch_idx_o_c
);

    localparam int unsigned      CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] N_EXP_C = CNT_W'(N_EXP);

    logic [ADDR_W-1:0] addr_q [N_EXP];
    logic [DATA_W-1:0] data_q [N_EXP];
    logic [N_EXP-1:0]  matched_q;

    // Table contents carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (wr_en_i && ({1'b0, wr_idx_i} < N_EXP_C)) begin
            addr_q[wr_idx_i] <= wr_addr_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matched_q <= '0;
        end else if (clr_i) begin
            matched_q <= '0;
        end else if (mark_i) begin
            matched_q[mark_idx_i] <= 1'b1;
        end
    end

    always_comb begin
        rd_addr_o_c = '0;
        rd_data_o_c = '0;
        if ({1'b0, rd_idx_i} < N_EXP_C) begin
            rd_addr_o_c = addr_q[rd_idx_i];
            rd_data_o_c = data_q[rd_idx_i];
        end
    end

    // Walk downwards so the lowest data-correct candidate wins.
    always_comb begin
        srch_hit_o_c     = 1'b0;
        srch_data_ok_o_c = 1'b0;
        srch_idx_o_c     = '0;
        for (int i = int'(N_EXP) - 1; i >= 0; i--) begin
            if (!matched_q[i] && (CNT_W'(i) < srch_count_i) &&
                (addr_q[i] == srch_addr_i)) begin
                srch_hit_o_c = 1'b1;
                if (data_q[i] == srch_data_i) begin
                    srch_data_ok_o_c = 1'b1;
                    srch_idx_o_c     = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor on the core's data-memory write port: compares stores
// against a programmed table and reports a sticky pass/fail verdict.
module mem_write_checker
    import mem_chk_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned N_EXP          = 4,
    parameter int unsigned ORDERED        = 1,
    parameter int unsigned IGN_LO         = 96,
    parameter int unsigned IGN_HI         = 96,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CYC_W          = 32,
    parameter int unsigned IDX_W          = idx_width(N_EXP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_count,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CYC_W-1:0]  cycles
);

    localparam int unsigned       CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0]  N_EXP_C   = CNT_W'(N_EXP);
    localparam logic [ADDR_W-1:0] IGN_LO_A  = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_HI_A  = ADDR_W'(IGN_HI);
    localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int unsigned       TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CYC_W-1:0]  TO_LAST   = CYC_W'(TO_LAST_I);

    state_e            state_q, state_d;
    fail_code_e        fail_code_q, fail_code_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;

    logic              tbl_we_c;
    logic              clr_c;
    logic              mark_c;
    logic [IDX_W-1:0]  mark_idx_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              srch_hit_c;
    logic              srch_ok_c;
    logic [IDX_W-1:0]  srch_idx_c;
    logic              ign_c;
    logic              hit_ok_c;
    logic              bad_data_c;

    // The table is frozen while a run is armed.
    assign tbl_we_c = cfg_we && (state_q != ST_ARMED);

    exp_store_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_EXP  (N_EXP),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk              (clk),
        .rst_n            (reset),
        .wr_en_i          (tbl_we_c),
        .wr_idx_i         (cfg_idx),
        .wr_addr_i        (cfg_addr),
        .wr_data_i        (cfg_data),
        .clr_i            (clr_c),
        .mark_i           (mark_c),
        .mark_idx_i       (mark_idx_c),
        .rd_idx_i         (match_cnt_q[IDX_W-1:0]),
        .rd_addr_o_c      (rd_addr_c),
        .rd_data_o_c      (rd_data_c),
        .srch_addr_i      (data_adr),
        .srch_data_i      (write_data),
        .srch_count_i     (cnt_q),
        .srch_hit_o_c     (srch_hit_c),
        .srch_data_ok_o_c (srch_ok_c),
        .srch_idx_o_c     (srch_idx_c)
    );

    assign ign_c = (data_adr >= IGN_LO_A) && (data_adr <= IGN_HI_A);

    // Classify the current store against the next (ordered) or any unmatched entry.
    always_comb begin
        hit_ok_c   = 1'b0;
        bad_data_c = 1'b0;
        mark_idx_c = srch_idx_c;
        if (ORDERED != 0) begin
            hit_ok_c   = (rd_addr_c == data_adr) && (rd_data_c == write_data);
            bad_data_c = (rd_addr_c == data_adr) && (rd_data_c != write_data);
            mark_idx_c = match_cnt_q[IDX_W-1:0];
        end else begin
            hit_ok_c   = srch_ok_c;
            bad_data_c = srch_hit_c && !srch_ok_c;
        end
    end

    always_comb begin
        logic       v_pass;
        logic       v_fail;
        fail_code_e v_code;

        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        cnt_d       = cnt_q;
        match_cnt_d = match_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        cycles_d    = cycles_q;
        clr_c       = 1'b0;
        mark_c      = 1'b0;
        v_pass      = 1'b0;
        v_fail      = 1'b0;
        v_code      = FC_NONE;

        case (state_q)
            ST_ARMED: begin
                if (cnt_q == '0) begin
                    v_pass = 1'b1;
                end else begin
                    if (mem_write && !ign_c) begin
                        if (hit_ok_c) begin
                            mark_c      = 1'b1;
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                            v_pass      = (match_cnt_d == cnt_q);
                        end else begin
                            v_fail      = 1'b1;
                            v_code      = bad_data_c ? FC_DATA : FC_ADDR;
                            fail_addr_d = data_adr;
                            fail_data_d = write_data;
                        end
                    end
                    // A store verdict on this edge takes precedence over the timeout.
                    if (!v_pass && !v_fail && TO_EN && (cycles_q == TO_LAST)) begin
                        v_fail      = 1'b1;
                        v_code      = FC_TIMEOUT;
                        fail_addr_d = '0;
                        fail_data_d = '0;
                    end
                end
                if (v_pass || v_fail) begin
                    state_d     = v_pass ? ST_PASS : ST_FAIL;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = v_pass;
                    fail_code_d = v_code;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_d     = ST_ARMED;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = FC_NONE;
                    cnt_d       = (cfg_count > N_EXP_C) ? N_EXP_C : cfg_count;
                    match_cnt_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    cycles_d    = '0;
                    clr_c       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            cnt_q       <= '0;
            match_cnt_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            cycles_q    <= cycles_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign match_cnt = match_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered and an unordered instance share one
// stimulus stream; verdicts are scored against a transaction-level model.
module tb_mem_write_checker;

    localparam int NE = 4;
    localparam int TO = 20;
    localparam int NC = 22;
    localparam int IGN_LO = 96;
    localparam int IGN_HI = 96;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  cfg_count = '0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;

    logic        o_busy, o_done, o_pass, u_busy, u_done, u_pass;
    logic [1:0]  o_fc, u_fc;
    logic [2:0]  o_mc, u_mc;
    logic [31:0] o_fa, o_fd, o_cyc, u_fa, u_fd, u_cyc;

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .N_EXP(NE), .ORDERED(1), .IGN_LO(IGN_LO),
        .IGN_HI(IGN_HI), .TIMEOUT_CYCLES(TO), .CYC_W(32)
    ) u_ord (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(o_busy), .done(o_done), .pass(o_pass),
        .fail_code(o_fc), .match_cnt(o_mc), .fail_addr(o_fa),
        .fail_data(o_fd), .cycles(o_cyc)
    );

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .N_EXP(NE), .ORDERED(0), .IGN_LO(IGN_LO),
        .IGN_HI(IGN_HI), .TIMEOUT_CYCLES(TO), .CYC_W(32)
    ) u_uno (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(u_busy), .done(u_done), .pass(u_pass),
        .fail_code(u_fc), .match_cnt(u_mc), .fail_addr(u_fa),
        .fail_data(u_fd), .cycles(u_cyc)
    );

    typedef struct {
        bit          pass;
        int          code;
        int          mcnt;
        logic [31:0] fa;
        logic [31:0] fd;
        int          cyc;
        int          ed;
    } exp_t;

    exp_t q_o[$];
    exp_t q_u[$];

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    bit o_prev = 1'b0;
    bit u_prev = 1'b0;

    logic [31:0] tbl_a [NE];
    logic [31:0] tbl_d [NE];
    int          cnt_in;
    bit          s_we [NC];
    logic [31:0] s_a  [NC];
    logic [31:0] s_d  [NC];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Verdict of one run straight from the store rules, one armed cycle at a time.
    function automatic exp_t model(input bit ordered, input int arm_edge);
        exp_t e;
        bit   matched [NE];
        int   cnt;
        int   m;
        bit   verdict;
        cnt = (cnt_in > NE) ? NE : cnt_in;
        m = 0;
        verdict = 1'b0;
        e.pass = 1'b0; e.code = 0; e.mcnt = 0; e.fa = '0; e.fd = '0; e.cyc = 0; e.ed = 0;
        for (int i = 0; i < NE; i++) matched[i] = 1'b0;
        for (int c = 0; c < NC && !verdict; c++) begin
            if (cnt == 0) begin
                verdict = 1'b1;
                e.pass  = 1'b1;
            end else begin
                if (s_we[c] && !(s_a[c] >= IGN_LO && s_a[c] <= IGN_HI)) begin
                    int  hit;
                    bit  found;
                    hit = -1;
                    found = 1'b0;
                    if (ordered) begin
                        found = (tbl_a[m] == s_a[c]);
                        if (found && tbl_d[m] == s_d[c]) hit = m;
                    end else begin
                        for (int i = 0; i < cnt; i++) begin
                            if (!matched[i] && tbl_a[i] == s_a[c]) begin
                                found = 1'b1;
                                if (tbl_d[i] == s_d[c] && hit < 0) hit = i;
                            end
                        end
                    end
                    if (hit >= 0) begin
                        matched[hit] = 1'b1;
                        m++;
                        if (m == cnt) begin verdict = 1'b1; e.pass = 1'b1; end
                    end else begin
                        verdict = 1'b1;
                        e.code = found ? 2 : 1;
                        e.fa = s_a[c];
                        e.fd = s_d[c];
                    end
                end
                if (!verdict && c == TO - 1) begin
                    verdict = 1'b1;
                    e.code = 3;
                end
            end
            if (verdict) begin
                e.cyc  = c;
                e.ed   = arm_edge + 1 + c;
                e.mcnt = m;
            end
        end
        return e;
    endfunction

    task automatic cmp(input string t, input exp_t e, input logic busy, input logic pass,
                       input logic [1:0] fc, input logic [2:0] mc, input logic [31:0] fa,
                       input logic [31:0] fd, input logic [31:0] cyc);
        chk({t, "_pass"}, 64'(pass), 64'(e.pass));
        chk({t, "_code"}, 64'(fc), 64'(e.code));
        chk({t, "_match_cnt"}, 64'(mc), 64'(e.mcnt));
        chk({t, "_fail_addr"}, 64'(fa), 64'(e.fa));
        chk({t, "_fail_data"}, 64'(fd), 64'(e.fd));
        chk({t, "_cycles"}, 64'(cyc), 64'(e.cyc));
        chk({t, "_verdict_edge"}, 64'(edge_n), 64'(e.ed));
        chk({t, "_busy_at_verdict"}, 64'(busy), 64'd0);
    endtask

    // Scoreboard monitors: each rising done pops one expected verdict.
    initial forever begin
        @(posedge clk); #2;
        if (o_done && !o_prev) begin
            if (q_o.size() == 0) chk("ord_unexpected_done", 64'(o_done), 64'd0);
            else cmp("ord", q_o.pop_front(), o_busy, o_pass, o_fc, o_mc, o_fa, o_fd, o_cyc);
        end
        o_prev = o_done;
    end

    initial forever begin
        @(posedge clk); #2;
        if (u_done && !u_prev) begin
            if (q_u.size() == 0) chk("uno_unexpected_done", 64'(u_done), 64'd0);
            else cmp("uno", q_u.pop_front(), u_busy, u_pass, u_fc, u_mc, u_fa, u_fd, u_cyc);
        end
        u_prev = u_done;
    end

    task automatic idle_inputs();
        cfg_we = 1'b0; start = 1'b0; mem_write = 1'b0;
        data_adr = '0; write_data = '0;
    endtask

    task automatic clr_stream();
        for (int c = 0; c < NC; c++) begin s_we[c] = 1'b0; s_a[c] = '0; s_d[c] = '0; end
    endtask

    task automatic write_table();
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = tbl_a[i]; cfg_data = tbl_d[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic chk_zero(input string t, input logic busy, input logic done, input logic pass,
                            input logic [1:0] fc, input logic [2:0] mc, input logic [31:0] fa,
                            input logic [31:0] fd, input logic [31:0] cyc);
        chk({t, "_status"}, 64'({busy, done, pass, fc, mc}), 64'd0);
        chk({t, "_fail_addr"}, 64'(fa), 64'd0);
        chk({t, "_fail_data"}, 64'(fd), 64'd0);
        chk({t, "_cycles"}, 64'(cyc), 64'd0);
    endtask

    // One complete run: program table, arm, drive NC armed cycles, drain.
    task automatic do_run(input bit inject);
        exp_t eo, eu;
        int   arm, lim;
        bit   inj_st [NC];
        bit   inj_we [NC];
        write_table();
        cfg_count = 3'(cnt_in);
        start = 1'b1;
        arm = edge_n + 1;
        eo = model(1'b1, arm);
        eu = model(1'b0, arm);
        q_o.push_back(eo);
        q_u.push_back(eu);
        lim = (eo.cyc < eu.cyc) ? eo.cyc : eu.cyc;
        for (int c = 0; c < NC; c++) begin
            inj_st[c] = inject && (c < lim) && ($urandom % 6 == 0);
            inj_we[c] = inject && (c < lim) && ($urandom % 6 == 0);
        end
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("ord_rearm", 64'({o_busy, o_done, o_pass, o_mc}), 64'h20);
                chk("ord_rearm_cycles", 64'(o_cyc), 64'd0);
                chk("uno_rearm", 64'({u_busy, u_done, u_pass, u_mc}), 64'h20);
                chk("uno_rearm_cycles", 64'(u_cyc), 64'd0);
            end
            start = inj_st[c];
            cfg_we = inj_we[c];
            cfg_idx = 2'($urandom % 4);
            cfg_addr = $urandom;
            cfg_data = $urandom;
            cfg_count = 3'($urandom % 8);
            mem_write = s_we[c];
            data_adr = s_a[c];
            write_data = s_d[c];
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic gen_random();
        int  eff, p, kind, k, j;
        bit  sparse;
        cnt_in = int'($urandom % 8);
        for (int i = 0; i < NE; i++) begin
            tbl_a[i] = 32'(100 + 4 * ($urandom % 6));
            tbl_d[i] = 32'($urandom % 4);
        end
        eff = (cnt_in == 0) ? 1 : ((cnt_in > NE) ? NE : cnt_in);
        p = 0;
        sparse = ($urandom % 5 == 0);
        for (int c = 0; c < NC; c++) begin
            s_we[c] = sparse ? ($urandom % 10 == 0) : ($urandom % 4 != 0);
            kind = int'($urandom % 20);
            k = p % eff;
            j = int'($urandom % NE);
            if (kind < 14) begin
                s_a[c] = tbl_a[k]; s_d[c] = tbl_d[k];
                if (s_we[c]) p++;
            end else if (kind < 16) begin
                s_a[c] = tbl_a[j]; s_d[c] = tbl_d[j];
            end else if (kind < 18) begin
                s_a[c] = 32'(IGN_LO); s_d[c] = $urandom;
            end else if (kind == 18) begin
                s_a[c] = tbl_a[k]; s_d[c] = tbl_d[k] + 32'd1;
            end else begin
                s_a[c] = 32'(300 + 4 * ($urandom % 4)); s_d[c] = $urandom;
            end
        end
    endtask

    task automatic single_table(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < NE; i++) begin tbl_a[i] = 32'(500 + 4 * i); tbl_d[i] = 32'(i); end
        tbl_a[0] = a; tbl_d[0] = d;
        cnt_in = 1;
        clr_stream();
    endtask

    initial begin
        idle_inputs();
        #12;
        chk_zero("reset_ord", o_busy, o_done, o_pass, o_fc, o_mc, o_fa, o_fd, o_cyc);
        chk_zero("reset_uno", u_busy, u_done, u_pass, u_fc, u_mc, u_fa, u_fd, u_cyc);
        @(negedge clk);
        reset = 1'b1;

        // Ignored store then the single expected store.
        single_table(32'd100, 32'd25);
        s_we[0] = 1'b1; s_a[0] = 32'd96;  s_d[0] = 32'd7;
        s_we[1] = 1'b1; s_a[1] = 32'd100; s_d[1] = 32'd25;
        do_run(1'b0);
        chk("single_pass", 64'({o_done, o_pass, o_fc, o_mc}), 64'h61);

        single_table(32'd100, 32'd25);
        s_we[0] = 1'b1; s_a[0] = 32'd104; s_d[0] = 32'd25;
        do_run(1'b0);
        chk("bad_addr_code", 64'({o_done, o_pass, o_fc}), 64'h9);
        chk("bad_addr_fail_addr", 64'(o_fa), 64'd104);

        single_table(32'd100, 32'd25);
        s_we[0] = 1'b1; s_a[0] = 32'd100; s_d[0] = 32'd24;
        do_run(1'b0);
        chk("bad_data_code", 64'(o_fc), 64'd2);
        chk("bad_data_fail_data", 64'(o_fd), 64'd24);

        single_table(32'd100, 32'd25);
        do_run(1'b1);
        chk("timeout_code", 64'(o_fc), 64'd3);
        chk("timeout_cycles", 64'(o_cyc), 64'd19);

        single_table(32'd100, 32'd25);
        s_we[TO-1] = 1'b1; s_a[TO-1] = 32'd100; s_d[TO-1] = 32'd25;
        do_run(1'b0);
        chk("store_beats_timeout", 64'({o_pass, o_fc}), 64'h4);

        // Two entries consumed out of table order.
        single_table(32'd200, 32'd1);
        tbl_a[1] = 32'd204; tbl_d[1] = 32'd2; cnt_in = 2;
        s_we[0] = 1'b1; s_a[0] = 32'd204; s_d[0] = 32'd2;
        s_we[1] = 1'b1; s_a[1] = 32'd200; s_d[1] = 32'd1;
        do_run(1'b1);
        chk("unordered_pass", 64'({u_pass, u_fc}), 64'h4);
        chk("ordered_fail_addr", 64'(o_fa), 64'd204);

        // Reset mid-run after one match.
        single_table(32'd100, 32'd25);
        tbl_a[1] = 32'd104; tbl_d[1] = 32'd3; cnt_in = 2;
        write_table();
        cfg_count = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_write = 1'b1; data_adr = 32'd100; write_data = 32'd25;
        @(negedge clk);
        idle_inputs();
        chk("pre_reset_match_cnt", 64'(o_mc), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk_zero("midrun_reset_ord", o_busy, o_done, o_pass, o_fc, o_mc, o_fa, o_fd, o_cyc);
        chk_zero("midrun_reset_uno", u_busy, u_done, u_pass, u_fc, u_mc, u_fa, u_fd, u_cyc);
        @(negedge clk);
        reset = 1'b1;
        s_we[0] = 1'b1; s_a[0] = 32'd100; s_d[0] = 32'd25;
        s_we[3] = 1'b1; s_a[3] = 32'd104; s_d[3] = 32'd3;
        do_run(1'b1);

        repeat (60) begin
            gen_random();
            do_run(1'b1);
        end

        repeat (3) @(negedge clk);
        chk("ord_pending_verdicts", 64'(q_o.size()), 64'd0);
        chk("uno_pending_verdicts", 64'(q_u.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor on the core's data-memory write port (mem_write / data_adr / write_data).
- Holds a programmable table of expected stores. Flags PASS when every entry has been observed, and FAIL on an unexpected address, wrong data or timeout.
- Sits beside top in simulation and FPGA bring-up, so benches and board tests get one pass/fail verdict.
- Replaces ad-hoc per-program checks in each testbench.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
N_EXP, 4, expected-store table depth (>=1)
ORDERED, 1, 1 = stores must arrive in table order; 0 = any order
IGN_LO, 96, low bound of ignored-address window (inclusive)
IGN_HI, 96, high bound of ignored-address window (inclusive; IGN_HI<IGN_LO disables the window)
TIMEOUT_CYCLES, 1000, armed-cycle limit; 0 disables the timeout
CYC_W, 32, cycle counter width
IDX_W, $clog2(N_EXP) (min 1), derived index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  write one table entry
cfg_idx  in  IDX_W  table index
cfg_addr  in  ADDR_W  expected address
cfg_data  in  DATA_W  expected data
cfg_count  in  IDX_W+1  number of valid entries, sampled at start
start  in  1  arm the checker
mem_write  in  1  store strobe from core
data_adr  in  ADDR_W  store address
write_data  in  DATA_W  store data
busy  out  1  armed and checking
done  out  1  verdict reached, sticky
pass  out  1  verdict is pass
fail_code  out  2  0 none, 1 bad address, 2 bad data, 3 timeout
match_cnt  out  IDX_W+1  entries matched so far
fail_addr  out  ADDR_W  address of offending store
fail_data  out  DATA_W  data of offending store
cycles  out  CYC_W  armed cycles elapsed

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0, table valid count 0, matched bitmap cleared. Table contents are don't-care.
- States: IDLE, ARMED, PASS, FAIL.
- IDLE/PASS/FAIL, cfg_we=1: writes table[cfg_idx] <= {cfg_addr, cfg_data}. Ignored in ARMED. cfg_idx>=N_EXP is ignored.
- IDLE/PASS/FAIL, start=1: on the next edge enter ARMED.
  - Clears match_cnt, cycles, fail_*, done, pass and the bitmap.
  - Latches count = min(cfg_count, N_EXP).
  - count==0 goes straight to PASS (done=1, pass=1) one cycle later.
- ARMED, start=1: ignored. busy=1 throughout ARMED.
- ARMED, each rising edge with mem_write=1:
  - Address in [IGN_LO, IGN_HI]: no effect, even when data differs.
  - ORDERED=1:
    - data_adr==table[match_cnt].addr and data matches: match_cnt++.
    - Address matches, data differs: FAIL, code 2.
    - Any other address: FAIL, code 1.
  - ORDERED=0: search unmatched entries with idx<count for an address match.
    - Hit with the correct data: mark the lowest such index, match_cnt++.
    - Address found but data wrong at every candidate: code 2.
    - No address found: code 1.
  - Final match (match_cnt reaches count): PASS.
  - On FAIL: fail_addr/fail_data capture the offending store.
- cycles increments every ARMED cycle and saturates at all-ones.
- Timeout: when TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 at an edge with no verdict that edge → FAIL, code 3, fail_addr/fail_data=0.
- Store verdict beats timeout on the same edge.
- All outputs are registered. The verdict is visible the cycle after the deciding edge.
- done/pass/fail_code hold until the next start or reset. cycles freezes at the verdict.
- reset asserted mid-ARMED: immediate return to IDLE with all outputs 0.

Decomposition:
- Package mem_chk_pkg:
  - state enum (IDLE, ARMED, PASS, FAIL).
  - fail_code enum (FC_NONE=0, FC_ADDR=1, FC_DATA=2, FC_TIMEOUT=3).
- Sub-module exp_store_table: the N_EXP-entry register file plus matched bitmap. It provides:
  - ordered lookup by index;
  - unordered first-unmatched-address-hit search returning hit, data_ok and idx;
  - a mark/clear interface.
- FSM, counters and verdict capture stay in mem_write_checker.

Test Plan:
- Single entry: count=1, table[0]={100,25}. Stores (96,7) then (100,25). → pass=1, fail_code=0, match_cnt=1, done one cycle after the second store.
- Bad address: same table, store (104,25). → done=1, pass=0, fail_code=1, fail_addr=104, fail_data=25.
- Bad data: store (100,24). → fail_code=2, fail_data=24.
- Timeout: TIMEOUT_CYCLES=20, no stores. → done on the 21st edge after arming, fail_code=3, cycles=19. Also a final matching store on the timeout edge. → pass=1.
- Unordered: ORDERED=0, count=2, table {(200,1),(204,2)}. Stores (204,2) then (200,1). → pass=1. Same stores with ORDERED=1. → fail_code=1, fail_addr=204.
- Robustness:
  - reset low mid-ARMED after one match. → all outputs 0 immediately.
  - start during ARMED. → no effect.
  - re-arm after PASS. → fresh run with cycles=0.
